// File: rtl/uart_pkg.sv
// Shared UART constants and the transmit FSM state encoding.
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_DATA_W     = 8;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } uartState_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr. It returns a one-hot grant
// and the pointer value that follows the winner.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] nextPtr
);

  int unsigned idx;
  logic        found;

  // Scan requesters in rotated order; the first pending one wins.
  always_comb begin
    grant   = '0;
    nextPtr = ptr;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(ptr) + k) % N_REQ;
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        nextPtr    = PTR_W'((idx + 1) % N_REQ);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin UART transmit scheduler. It grants one requester and latches its
// byte, then serialises an 8N1 frame. Defining UART_PARITY_EN adds an even
// parity bit, which makes the frame 8E1. Each bit lasts OVERSAMPLE ticks.
module uart_tx_sched import uart_pkg::*; #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_W     = UART_DATA_W,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data,
  output logic [N_REQ-1:0]        gnt,
  output logic                    busy,
  output logic                    done,
  output logic                    txd
);

  localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW = $clog2(DATA_W);

  uartState_t        stateQ, stateD;
  logic [CntW-1:0]   tickCntQ, tickCntD;
  logic [BitW-1:0]   bitCntQ, bitCntD;
  logic [DATA_W-1:0] shiftQ, shiftD;
  logic [PtrW-1:0]   ptrQ, ptrD;
  logic              txdQ, txdD;
  logic              busyQ, busyD;
  logic              doneQ, doneD;
  logic [N_REQ-1:0]  gntQ, gntD;
`ifdef UART_PARITY_EN
  logic              parQ, parD;
`endif

  logic [N_REQ-1:0]  arbGrant;
  logic [PtrW-1:0]   arbNextPtr;
  logic [DATA_W-1:0] selData;
  logic              bitEnd;
  logic              lastBit;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PtrW)
  ) uArb (
    .req     (req),
    .ptr     (ptrQ),
    .en      (stateQ == StIdle),
    .grant   (arbGrant),
    .nextPtr (arbNextPtr)
  );

  assign bitEnd  = tick && (tickCntQ == CntW'(OVERSAMPLE - 1));
  assign lastBit = (bitCntQ == BitW'(DATA_W - 1));

  // Select the winning requester's byte for capture.
  always_comb begin
    selData = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (arbGrant[i]) selData = data[i*DATA_W +: DATA_W];
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stateQ   <= StIdle;
      tickCntQ <= '0;
      bitCntQ  <= '0;
      shiftQ   <= '0;
      ptrQ     <= '0;
      txdQ     <= 1'b1;
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
      gntQ     <= '0;
`ifdef UART_PARITY_EN
      parQ     <= 1'b0;
`endif
    end else begin
      stateQ   <= stateD;
      tickCntQ <= tickCntD;
      bitCntQ  <= bitCntD;
      shiftQ   <= shiftD;
      ptrQ     <= ptrD;
      txdQ     <= txdD;
      busyQ    <= busyD;
      doneQ    <= doneD;
      gntQ     <= gntD;
`ifdef UART_PARITY_EN
      parQ     <= parD;
`endif
    end
  end

  // Next-state logic: advance only at the end of a bit period.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      StIdle:   if (|req) stateD = StStart;
      StStart:  if (bitEnd) stateD = StData;
`ifdef UART_PARITY_EN
      StData:   if (bitEnd && lastBit) stateD = StParity;
      StParity: if (bitEnd) stateD = StStop;
`else
      StData:   if (bitEnd && lastBit) stateD = StStop;
`endif
      StStop:   if (bitEnd) stateD = StIdle;
      default:  stateD = StIdle;
    endcase
  end

  // Output and datapath next values: grant capture, tick counting, bit shifting.
  always_comb begin
    tickCntD = tickCntQ;
    bitCntD  = bitCntQ;
    shiftD   = shiftQ;
    ptrD     = ptrQ;
    txdD     = txdQ;
    busyD    = busyQ;
    doneD    = 1'b0;
    gntD     = '0;
`ifdef UART_PARITY_EN
    parD     = parQ;
`endif
    // A tick on the grant edge falls in IDLE, so it is not counted.
    if (stateQ != StIdle && tick) begin
      tickCntD = bitEnd ? '0 : tickCntQ + 1'b1;
    end
    case (stateQ)
      StIdle: begin
        txdD = 1'b1;
        if (|req) begin
          gntD     = arbGrant;
          ptrD     = arbNextPtr;
          shiftD   = selData;
          txdD     = 1'b0;
          busyD    = 1'b1;
          tickCntD = '0;
          bitCntD  = '0;
`ifdef UART_PARITY_EN
          parD     = ^selData;
`endif
        end
      end
      StStart: begin
        if (bitEnd) txdD = shiftQ[0];
      end
      StData: begin
        if (bitEnd) begin
          if (lastBit) begin
`ifdef UART_PARITY_EN
            txdD = parQ;
`else
            txdD = 1'b1;
`endif
          end else begin
            shiftD  = shiftQ >> 1;
            txdD    = shiftQ[1];
            bitCntD = bitCntQ + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      StParity: begin
        if (bitEnd) txdD = 1'b1;
      end
`endif
      StStop: begin
        if (bitEnd) begin
          doneD = 1'b1;
          busyD = 1'b0;
          txdD  = 1'b1;
        end
      end
      default: begin
        txdD  = 1'b1;
        busyD = 1'b0;
      end
    endcase
  end

  assign gnt  = gntQ;
  assign busy = busyQ;
  assign done = doneQ;
  assign txd  = txdQ;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomised bench for uart_tx_sched. It uses a frame-level reference model
// for round-robin winner selection and the expected serial bit sequence.
module tb_uart_tx_sched;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int OS = 16;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tick = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*DW-1:0] data = '0;
  logic [N-1:0]  gnt;
  logic          busy;
  logic          done;
  logic          txd;

  int errors = 0;
  int checks = 0;
  int mPtr   = 0;

  uart_tx_sched #(
    .N_REQ      (N),
    .DATA_W     (DW),
    .OVERSAMPLE (OS)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .req  (req),
    .data (data),
    .gnt  (gnt),
    .busy (busy),
    .done (done),
    .txd  (txd)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clkStep(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  // The grant edge is the first step. Bits are sampled mid-period by tick count.
  task automatic runFrame(input bit periodic, input int stall, input int abortBit,
                          input bit reassert);
    int w;
    int ticks;
    int j;
    int k;
    logic t;
    logic [DW-1:0] b;
    logic fb [0:10];
    bit sawDone;
    bit sawGnt;
    w = 0;
    for (int m = N - 1; m >= 0; m--) begin
      if (req[(mPtr + m) % N]) w = (mPtr + m) % N;
    end
    b = data[w*DW +: DW];
    fb[0] = 1'b0;
    for (int i = 0; i < DW; i++) fb[1+i] = b[i];
    fb[9]  = ^b;
    fb[10] = 1'b1;
    fb[NBITS-1] = 1'b1;

    clkStep(1'($urandom_range(0, 1)));
    checkVal("gnt", 32'(gnt), 32'(1) << w);
    checkVal("start_txd", 32'(txd), 0);
    checkVal("start_busy", 32'(busy), 1);
    mPtr = (w + 1) % N;
    req[w] = reassert;
    data[w*DW +: DW] = DW'($urandom);
    clkStep(1'b0);
    checkVal("gnt_pulse", 32'(gnt), 0);
    checkVal("done_quiet", 32'(done), 0);
    if (stall > 0) begin
      repeat (stall) clkStep(1'b0);
      checkVal("stall_txd", 32'(txd), 0);
      checkVal("stall_busy", 32'(busy), 1);
    end
    ticks = 0;
    j = 1;
    while (ticks < NBITS * OS) begin
      if (j > 30000) begin
        checkVal("frame_timeout", ticks, NBITS * OS);
        return;
      end
      j++;
      t = periodic ? (j % 4 == 0) : ($urandom_range(0, 2) == 0);
      clkStep(t);
      if (t) begin
        ticks++;
        if (ticks % OS == OS / 2) begin
          k = ticks / OS;
          checkVal($sformatf("bit%0d", k), 32'(txd), 32'(fb[k]));
          checkVal("busy_mid", 32'(busy), 1);
          if (k == abortBit) begin
            rst = 1'b0;
            clkStep(1'b0);
            checkVal("abort_txd", 32'(txd), 1);
            checkVal("abort_busy", 32'(busy), 0);
            checkVal("abort_done", 32'(done), 0);
            rst = 1'b1;
            mPtr = 0;
            sawDone = 1'b0;
            sawGnt = 1'b0;
            repeat (50) begin
              clkStep(1'($urandom_range(0, 1)));
              sawDone |= done;
              sawGnt  |= |gnt;
            end
            checkVal("abort_no_done", 32'(sawDone), 0);
            checkVal("abort_no_regrant", 32'(sawGnt), 0);
            return;
          end
        end
        if (ticks == NBITS * OS - 1) checkVal("done_early", 32'(done), 0);
      end
    end
    checkVal("done", 32'(done), 1);
    checkVal("end_busy", 32'(busy), 0);
    checkVal("end_txd", 32'(txd), 1);
    if (periodic && stall == 0) checkVal("frame_clks", j, NBITS * OS * 4);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) clkStep(1'b0);
    checkVal("rst_txd", 32'(txd), 1);
    checkVal("rst_busy", 32'(busy), 0);
    checkVal("rst_done", 32'(done), 0);
    checkVal("rst_gnt", 32'(gnt), 0);
    rst = 1'b1;
    clkStep(1'b1);
    checkVal("idle_gnt", 32'(gnt), 0);
    checkVal("idle_txd", 32'(txd), 1);

    // Single byte A5 from requester 0, tick every 4 clocks.
    req = 4'b0001;
    data[7:0] = 8'hA5;
    runFrame(1'b1, 0, -1, 1'b0);
    clkStep(1'b0);
    checkVal("after_busy", 32'(busy), 0);
    checkVal("after_done", 32'(done), 0);
    checkVal("after_gnt", 32'(gnt), 0);

    // Round robin with all requesters re-asserting.
    req = 4'b1111;
    for (int i = 0; i < N; i++) data[i*DW +: DW] = DW'($urandom);
    repeat (5) runFrame(1'b0, 0, -1, 1'b1);

    // Priority wrap: grant 3, then 1001 must go to 0.
    req = 4'b1000;
    runFrame(1'b0, 0, -1, 1'b0);
    req = 4'b1001;
    runFrame(1'b0, 0, -1, 1'b0);

    // Long tick starvation after grant.
    req = 4'b0100;
    runFrame(1'b1, 1000, -1, 1'b0);

    // Random traffic, including withdrawn requests.
    repeat (12) begin
      req = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) data[i*DW +: DW] = DW'($urandom);
      runFrame(1'($urandom_range(0, 1)), 0, -1, 1'($urandom_range(0, 1)));
    end

    // Reset during data bit 3, then a fresh request.
    req = 4'b0010;
    data[DW +: DW] = DW'($urandom);
    runFrame(1'b0, 0, 4, 1'b0);
    req = 4'b0100;
    data[2*DW +: DW] = 8'h07;
    runFrame(1'b0, 0, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin transmit scheduler that shares one UART serial output between several byte producers. It sits between the 16× oversampling baud tick generator and the board TXD pin. It arbitrates among pending requesters and latches the winning byte. It then serialises that byte as an 8N1 frame, or 8E1 when parity is compiled in, stepping each bit on 16 baud ticks.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `DATA_W`, 8: bits per character.
- `OVERSAMPLE`, 16: ticks per bit period; must be a power of two.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-low.
- `tick`  in  1  single-cycle pulse from the baud generator at 16× baud rate.
- `req`  in  N_REQ  per-requester "byte pending". Held high until granted.
- `data`  in  N_REQ*DATA_W  requester i's byte at `[i*DATA_W +: DATA_W]`.
- `gnt`  out  N_REQ  one-hot, one-cycle pulse. Marks the cycle the byte is captured.
- `busy`  out  1  high from grant until the end of the stop bit.
- `done`  out  1  one-cycle pulse at the end of the stop bit.
- `txd`  out  1  serial line, idle high.

## Operation
- States: IDLE, START, DATA, PARITY (only when the macro is defined), STOP.
- IDLE, with any `req` bit set: the next edge performs all of the following:
  - grants the winner, with `gnt` one-hot for one cycle;
  - loads the shift register from that requester's `data` slice;
  - drives `txd`=0 and sets `busy`=1;
  - clears the tick counter and bit counter;
  - moves to START.
- Round robin: the search starts at `ptr`. After granting requester i, `ptr` becomes (i+1) mod N_REQ. Reset sets `ptr`=0.
- Bit period: a 4-bit tick counter increments on each `tick`. A bit ends on a `tick` with counter == OVERSAMPLE-1; the counter then wraps to 0. Cycles without `tick` hold all state.
- START end: `txd` takes shift[0] and the state moves to DATA.
- DATA: the line sends LSB first. Each bit end shifts right and increments the bit counter.
  - After bit DATA_W-1 ends, go to PARITY (`txd` = even parity, the XOR of the latched byte) or to STOP (`txd`=1).
- PARITY end: `txd`=1, go to STOP.
- STOP end: pulse `done`, clear `busy`, return to IDLE with `txd` held 1.
- Requests seen in DATA, PARITY or STOP are not granted until IDLE. Dropping `req` after `gnt` has no effect on the frame. Dropping `req` before grant withdraws it silently.

## Timing
- Reset values: `txd`=1, `busy`=0, `done`=0, `gnt`=0, state IDLE, `ptr`=0, all counters 0.
- Reset mid-frame: on the next edge `txd`=1 and `busy`=0. No `done` pulse. The byte is lost and no second `gnt` is issued for it.
- Grant latency: 1 cycle from `req` sampled high in IDLE to `gnt`/`txd`=0.
- Start bit length: exactly OVERSAMPLE ticks counted after the grant edge.
- Frame length: 10·OVERSAMPLE ticks, or 11·OVERSAMPLE with parity.
- Back-to-back frames: after `done`, IDLE lasts at least 1 clk cycle before the next `gnt`.
  - A `req` held high across `done` is granted on the edge following the IDLE entry.
  - This gives a minimum gap of 1 clk of extra stop.
- `tick` asserted in the same cycle as the grant edge is not counted.
- `done` and `busy` falling coincide on the same edge.

## Configuration
- `UART_PARITY_EN` defined: the PARITY state is built, an even parity bit is sent after the data bits, and the frame is 11 bits.
- Undefined: no PARITY state, no parity logic, and the frame is 10 bits (8N1).

## Structure
- Package `uart_pkg`:
  - state encoding constants (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4);
  - `UART_OVERSAMPLE`=16;
  - the default character width.
- The baud generator also includes `uart_pkg`.
- Sub-module `rr_arbiter`, parameter N_REQ:
  - inputs `req`, `ptr`, `en`;
  - outputs a one-hot `grant` and the next `ptr`.
- The parent holds the FSM, counters and shift register.

## Test plan
- Reset mid-frame: assert `rst`=0 during DATA bit 3 → `txd`=1 and `busy`=0 next edge; no `done`; a new `req` after release is granted normally.
- Single byte: `req`=0001, data0=8'hA5, `tick` every 4 clks → `gnt`=0001 one cycle, then `txd` sequence 0,1,0,1,0,0,1,0,1,1. Each bit lasts 64 clks, `done` arrives after 640 clks.
- Round robin: `req`=1111 held, each requester re-asserting after grant → grant order 0,1,2,3,0; exactly one `gnt` bit per frame.
- Priority wrap: after a grant to requester 3, `req`=1001 → next grant is 0, not 3.
- No tick: `tick` held 0 for 1000 clks after grant → `txd` stays 0, state unchanged, `busy`=1.
- `UART_PARITY_EN` defined: data 8'h07 → parity bit 1 after the data bits; frame is 11·16 ticks.
